divider_fp: RTL and testbench

- Multi-cycle IEEE-754-style floating-point divider; the inverse companion of the FP multiplier in the parametrizable FPU.
- Computes o_result = i_A / i_B using a one-bit-per-cycle restoring mantissa divider, then normalizes and rounds to nearest-even.
- Uses the same SIZE/EXPONENT/FRACTION/BIAS parametrization and start/done handshake as the multiplier, so both can sit behind one FPU control wrapper.

---
 rtl/divider_fp.sv | 228 ++++++++++++++++++++++
 tb/tb_divider_fp.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/divider_fp.sv
`default_nettype none
// ============================================================================
// Module   : divider_fp
// Brief    : Multi-cycle IEEE-754-style FP divider, restoring 1-bit/cycle
//            mantissa divide, round-to-nearest-even, start/done handshake.
// Revision : 1.0
// ============================================================================
module divider_fp #(
    parameter int SIZE     = 32,
    parameter int EXPONENT = 5 + ($clog2(SIZE) - 4) * 3,
    parameter int FRACTION = SIZE - EXPONENT - 1,
    parameter int BIAS     = 2**(EXPONENT - 1) - 1
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_start,
    input  logic [SIZE-1:0] i_A,
    input  logic [SIZE-1:0] i_B,
    output logic [SIZE-1:0] o_result,
    output logic            o_done,
    output logic            o_busy,
    output logic [3:0]      o_flags
);
    localparam int ITERS = FRACTION + 4;
    localparam int MW    = FRACTION + 1;
    localparam int RW    = FRACTION + 2;
    localparam int EW    = EXPONENT + 2;
    localparam int CW    = $clog2(ITERS);
    localparam logic [CW-1:0] LAST_CNT = CW'(ITERS - 2);
    localparam logic [EW-2:0] EXP_INF  = (EW-1)'(2**EXPONENT - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_DIVIDE = 3'd2,
        S_NORM   = 3'd3,
        S_ROUND  = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t          state_q, state_d;
    logic            sign_q, sign_d;
    logic [EW-1:0]   exp_q, exp_d;
    logic [MW-1:0]   mb_q, mb_d;
    logic [RW-1:0]   rem_q, rem_d;
    logic [ITERS-1:0] quo_q, quo_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [MW-1:0]   mant_q, mant_d;
    logic            guard_q, guard_d;
    logic            round_q, round_d;
    logic            sticky_q, sticky_d;
    logic [SIZE-1:0] result_q, result_d;
    logic [3:0]      flags_q, flags_d;

    logic                w_sign_a, w_sign_b, w_sign;
    logic [EXPONENT-1:0] w_exp_a, w_exp_b;
    logic [FRACTION-1:0] w_frac_a, w_frac_b;
    logic                w_zero_a, w_zero_b, w_inf_a, w_inf_b, w_nan_a, w_nan_b;

    assign {w_sign_a, w_exp_a, w_frac_a} = i_A;
    assign {w_sign_b, w_exp_b, w_frac_b} = i_B;
    assign w_sign   = w_sign_a ^ w_sign_b;
    assign w_zero_a = (w_exp_a == '0);
    assign w_zero_b = (w_exp_b == '0);
    assign w_inf_a  = (&w_exp_a) && (w_frac_a == '0);
    assign w_inf_b  = (&w_exp_b) && (w_frac_b == '0);
    assign w_nan_a  = (&w_exp_a) && (|w_frac_a);
    assign w_nan_b  = (&w_exp_b) && (|w_frac_b);

    // The first restoring step runs in LOAD straight off the operand ports.
    logic [RW-1:0] w_rem_cur, w_rem_sub, w_rem_nxt;
    logic [MW-1:0] w_mb_cur;
    logic          w_qbit;

    always_comb begin
        if (state_q == S_LOAD) begin
            w_rem_cur = {2'b01, w_frac_a};
            w_mb_cur  = {1'b1, w_frac_b};
        end else begin
            w_rem_cur = rem_q;
            w_mb_cur  = mb_q;
        end
        w_qbit    = (w_rem_cur >= {1'b0, w_mb_cur});
        w_rem_sub = w_qbit ? (w_rem_cur - {1'b0, w_mb_cur}) : w_rem_cur;
        w_rem_nxt = w_rem_sub << 1;
    end

    logic                w_inc;
    logic [MW:0]         w_mant_r;
    logic [FRACTION-1:0] w_frac_f;
    logic [EW-1:0]       w_exp_f;
    logic                w_ovf, w_unf;

    always_comb begin
        w_inc    = guard_q & (round_q | sticky_q | mant_q[0]);
        w_mant_r = {1'b0, mant_q} + (MW+1)'(w_inc);
        w_frac_f = w_mant_r[MW] ? w_mant_r[FRACTION:1] : w_mant_r[FRACTION-1:0];
        w_exp_f  = w_mant_r[MW] ? (exp_q + EW'(1)) : exp_q;
        w_ovf    = !w_exp_f[EW-1] && (w_exp_f[EW-2:0] >= EXP_INF);
        w_unf    = w_exp_f[EW-1] || (w_exp_f == '0);
    end

    always_comb begin
        state_d  = state_q;
        sign_d   = sign_q;
        exp_d    = exp_q;
        mb_d     = mb_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        cnt_d    = cnt_q;
        mant_d   = mant_q;
        guard_d  = guard_q;
        round_d  = round_q;
        sticky_d = sticky_q;
        result_d = result_q;
        flags_d  = flags_q;
        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    state_d = S_LOAD;
                    flags_d = '0;
                end
            end
            S_LOAD: begin
                sign_d  = w_sign;
                exp_d   = EW'(w_exp_a) - EW'(w_exp_b) + EW'(BIAS);
                mb_d    = {1'b1, w_frac_b};
                rem_d   = w_rem_nxt;
                quo_d   = {{(ITERS-1){1'b0}}, w_qbit};
                cnt_d   = '0;
                state_d = S_DONE;
                if (w_nan_a || w_nan_b || (w_zero_a && w_zero_b) || (w_inf_a && w_inf_b)) begin
                    result_d = {1'b0, {EXPONENT{1'b1}}, 1'b1, {(FRACTION-1){1'b0}}};
                    flags_d  = 4'b1000;
                end else if (w_zero_b) begin
                    result_d = {w_sign, {EXPONENT{1'b1}}, {FRACTION{1'b0}}};
                    flags_d  = 4'b0100;
                end else if (w_inf_a) begin
                    result_d = {w_sign, {EXPONENT{1'b1}}, {FRACTION{1'b0}}};
                end else if (w_zero_a || w_inf_b) begin
                    result_d = {w_sign, {(SIZE-1){1'b0}}};
                end else begin
                    state_d = S_DIVIDE;
                end
            end
            S_DIVIDE: begin
                rem_d = w_rem_nxt;
                quo_d = {quo_q[ITERS-2:0], w_qbit};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST_CNT) begin
                    state_d = S_NORM;
                end
            end
            S_NORM: begin
                // Quotient is in (0.5, 2): at most one left shift normalizes it.
                if (quo_q[ITERS-1]) begin
                    mant_d   = quo_q[ITERS-1 -: MW];
                    guard_d  = quo_q[2];
                    round_d  = quo_q[1];
                    sticky_d = quo_q[0] | (|rem_q);
                end else begin
                    mant_d   = quo_q[ITERS-2 -: MW];
                    guard_d  = quo_q[1];
                    round_d  = quo_q[0];
                    sticky_d = |rem_q;
                    exp_d    = exp_q - EW'(1);
                end
                state_d = S_ROUND;
            end
            S_ROUND: begin
                if (w_ovf) begin
                    result_d = {sign_q, {EXPONENT{1'b1}}, {FRACTION{1'b0}}};
                end else if (w_unf) begin
                    result_d = {sign_q, {(SIZE-1){1'b0}}};
                end else begin
                    result_d = {sign_q, w_exp_f[EXPONENT-1:0], w_frac_f};
                end
                flags_d = {2'b00, w_ovf, w_unf && !w_ovf};
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= S_IDLE;
            sign_q   <= 1'b0;
            exp_q    <= '0;
            mb_q     <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            cnt_q    <= '0;
            mant_q   <= '0;
            guard_q  <= 1'b0;
            round_q  <= 1'b0;
            sticky_q <= 1'b0;
            result_q <= '0;
            flags_q  <= '0;
        end else begin
            state_q  <= state_d;
            sign_q   <= sign_d;
            exp_q    <= exp_d;
            mb_q     <= mb_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            cnt_q    <= cnt_d;
            mant_q   <= mant_d;
            guard_q  <= guard_d;
            round_q  <= round_d;
            sticky_q <= sticky_d;
            result_q <= result_d;
            flags_q  <= flags_d;
        end
    end

    assign o_result = result_q;
    assign o_flags  = flags_q;
    assign o_done   = (state_q == S_DONE);
    assign o_busy   = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_divider_fp.sv
`default_nettype none
// ============================================================================
// Module   : tb_divider_fp
// Brief    : Directed self-checking bench for divider_fp (SIZE=32).
// Revision : 1.0
// ============================================================================
module tb_divider_fp;
    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] a_in;
    logic [31:0] b_in;
    logic [31:0] result;
    logic        done;
    logic        busy;
    logic [3:0]  flags;

    int n_tests = 0;
    int n_fail  = 0;

    divider_fp #(.SIZE(32)) dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_start  (start),
        .i_A      (a_in),
        .i_B      (b_in),
        .o_result (result),
        .o_done   (done),
        .o_busy   (busy),
        .o_flags  (flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam int NV = 16;
    logic [31:0] va [NV];
    logic [31:0] vb [NV];
    logic [31:0] vr [NV];
    logic [3:0]  vf [NV];
    int          vl [NV];

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Returns at the negedge following the start-sampling edge.
    task automatic start_op(input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        a_in  = a;
        b_in  = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // lat0 = edges already elapsed since the start-sampling edge (inclusive).
    task automatic wait_done(input string tag, input int lat0, output int lat);
        bit busy_ok;
        busy_ok = 1'b1;
        lat     = lat0;
        while (!done && lat < 200) begin
            if (!busy) busy_ok = 1'b0;
            @(negedge clk);
            lat++;
        end
        if (!busy) busy_ok = 1'b0;
        check_value($sformatf("%s_done_seen", tag), 32'(done), 32'd1);
        check_value($sformatf("%s_busy", tag), 32'(busy_ok), 32'd1);
    endtask

    task automatic run_vec(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] er, input logic [3:0] ef, input int el);
        int lat;
        start_op(a, b);
        check_value($sformatf("%s_flags_clr", tag), 32'(flags), 32'd0);
        wait_done(tag, 1, lat);
        check_value($sformatf("%s_lat", tag), lat, el);
        check_value($sformatf("%s_res", tag), result, er);
        check_value($sformatf("%s_flags", tag), 32'(flags), 32'(ef));
        @(negedge clk);
        check_value($sformatf("%s_pulse", tag), 32'(done), 32'd0);
    endtask

    initial begin
        int lat;
        int seen;

        va = '{32'h40C00000, 32'h3F800000, 32'hBF800000, 32'h40000000, 32'h3F800000,
               32'h00000000, 32'h00000000, 32'h7F800000, 32'h7F800001, 32'hFF800000,
               32'h40000000, 32'hBF800000, 32'h00000001, 32'h7F000000, 32'h00800000,
               32'hC0C00000};
        vb = '{32'h40000000, 32'h40400000, 32'h40800000, 32'h40400000, 32'h00000000,
               32'h00000000, 32'h40000000, 32'hFF800000, 32'h3F800000, 32'h40000000,
               32'h7F800000, 32'h00000000, 32'h40000000, 32'h3E800000, 32'h7F000000,
               32'hC0000000};
        vr = '{32'h40400000, 32'h3EAAAAAB, 32'hBE800000, 32'h3F2AAAAB, 32'h7F800000,
               32'h7FC00000, 32'h00000000, 32'h7FC00000, 32'h7FC00000, 32'hFF800000,
               32'h00000000, 32'hFF800000, 32'h00000000, 32'h7F800000, 32'h00000000,
               32'h40400000};
        vf = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b1000, 4'b0000, 4'b1000,
               4'b1000, 4'b0000, 4'b0000, 4'b0100, 4'b0000, 4'b0010, 4'b0001, 4'b0000};
        vl = '{30, 30, 30, 30, 2, 2, 2, 2, 2, 2, 2, 2, 2, 30, 30, 30};

        rst   = 1'b1;
        start = 1'b0;
        a_in  = '0;
        b_in  = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_value("rst_result", result, 32'h0);
        check_value("rst_flags", 32'(flags), 32'h0);
        check_value("rst_done", 32'(done), 32'h0);
        check_value("rst_busy", 32'(busy), 32'h0);

        for (int i = 0; i < NV; i++) begin
            run_vec($sformatf("v%0d", i), va[i], vb[i], vr[i], vf[i], vl[i]);
        end

        // Start pulse mid-divide must be ignored.
        start_op(32'h40C00000, 32'h40000000);
        repeat (6) @(negedge clk);
        a_in  = 32'h3F800000;
        b_in  = 32'h40400000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("hs_mid", 8, lat);
        check_value("hs_mid_lat", lat, 30);
        check_value("hs_mid_res", result, 32'h40400000);

        // Start in the done cycle is ignored; held one more cycle it is accepted.
        a_in  = 32'h3F800000;
        b_in  = 32'h40400000;
        start = 1'b1;
        @(negedge clk);
        check_value("hs_b2b_busy", 32'(busy), 32'd0);
        check_value("hs_b2b_done", 32'(done), 32'd0);
        @(negedge clk);
        start = 1'b0;
        wait_done("hs_next", 1, lat);
        check_value("hs_next_lat", lat, 30);
        check_value("hs_next_res", result, 32'h3EAAAAAB);
        @(negedge clk);

        // Reset during the divide aborts without a done pulse.
        start_op(32'h40C00000, 32'h40000000);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_value("mr_busy", 32'(busy), 32'd0);
        check_value("mr_done", 32'(done), 32'd0);
        check_value("mr_result", result, 32'h0);
        check_value("mr_flags", 32'(flags), 32'h0);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) seen++;
        end
        check_value("mr_no_done", seen, 0);
        run_vec("mr_after", 32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000, 30);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
